// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 2-flop input sync, mid-bit sampling,
// start-glitch rejection, parity/framing/overrun reporting.
module uart_rx_oversampled #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ARM, IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t               state;
    logic                 rx_q1;
    logic                 rx_s;
    logic [1:0]           sync_fill;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 p_rx;
    logic                 tick;

    always_comb begin
        tick = (cnt == ((state == START) ? HALF : FULL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARM;
            rx_q1      <= 1'b1;
            rx_s       <= 1'b1;
            sync_fill  <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            p_rx       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_q1      <= rx;
            rx_s       <= rx_q1;
            sync_fill  <= {sync_fill[0], 1'b1};
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
            unique case (state)
                // the reset-value 1s in the synchronizer are not trusted
                ARM: begin
                    if (sync_fill[1] && rx_s) state <= IDLE;
                end
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == LAST) state <= PARITY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick) begin
                        cnt   <= '0;
                        p_rx  <= rx_s;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : ARM;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (p_rx != ~(^shreg)) begin
                            parity_err <= 1'b1;
                        end else begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            if (data_valid && !data_ack) overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Randomized bench for uart_rx_oversampled with a frame-level
// reference model and hand-pinned directed cases.
module tb_uart_rx_oversampled;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int LAT   = 3 + CPB / 2 + (DB + 2) * CPB;
    localparam int FRAME = (DB + 3) * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_line;
    logic          data_ack;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;

    uart_rx_oversampled #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx_line),
        .data_ack(data_ack),
        .data_out(data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 0;
    bit rand_ack = 0;

    // kind: 0 good, 1 parity error, 2 framing error
    typedef struct {
        int          c;
        int          kind;
        logic [7:0]  d;
    } ev_t;
    ev_t sched[$];

    logic [DB-1:0] m_data;
    logic          m_valid, m_perr, m_ferr, m_ovr;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h",
                      name, cyc, act, exp);
    endtask

    // Frame-level reference: outcome of each frame is decided when it is
    // sent and takes effect LAT edges after the start bit hits the pin.
    always @(posedge clk) begin
        bit  old_v;
        ev_t ev;
        cyc++;
        if (reset) begin
            m_data = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
            sched.delete();
        end else begin
            old_v  = m_valid;
            m_perr = 0;
            m_ferr = 0;
            if (data_ack && m_valid) begin
                m_valid = 0;
                m_ovr   = 0;
            end
            if (sched.size() > 0 && sched[0].c == cyc) begin
                ev = sched.pop_front();
                if (ev.kind == 2) m_ferr = 1;
                else if (ev.kind == 1) m_perr = 1;
                else begin
                    if (old_v && !data_ack) m_ovr = 1;
                    m_data  = ev.d;
                    m_valid = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out", 32'(data_out), 32'(m_data));
            check("data_valid", 32'(data_valid), 32'(m_valid));
            check("parity_err", 32'(parity_err), 32'(m_perr));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            check("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ack) data_ack = ($urandom_range(0, 3) == 0);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at #1 after a posedge; each bit is held CPB edges.
    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input int hold);
        logic par;
        ev_t  ev;
        par  = ~(^d) ^ bad_par;
        ev.c = cyc + LAT;
        ev.d = d;
        ev.kind = bad_stop ? 2 : (bad_par ? 1 : 0);
        sched.push_back(ev);
        rx_line = 1'b0;
        cycles(CPB);
        for (int i = 0; i < DB; i++) begin
            rx_line = d[i];
            cycles(CPB);
        end
        rx_line = par;
        cycles(CPB);
        rx_line = ~bad_stop;
        cycles(CPB);
        if (hold > 0) cycles(hold);
        rx_line = 1'b1;
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        cycles(1);
        data_ack = 1'b0;
    endtask

    initial begin
        int t0;
        reset    = 1'b1;
        rx_line  = 1'b1;
        data_ack = 1'b0;
        @(posedge clk);
        chk_en = 1;
        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst data_out", 32'(data_out), 32'h0);
        check("rst data_valid", 32'(data_valid), 32'h0);
        check("rst overrun", 32'(overrun), 32'h0);
        check("rst errs", 32'({parity_err, frame_err}), 32'h0);
        cycles(10);

        // good frame 0xA5, pinned latency of 171 edges
        t0 = cyc;
        fork
            send_frame(8'hA5, 0, 0, 0);
            begin
                at_cycle(t0 + 170);
                check("lat dv early", 32'(data_valid), 32'h0);
                at_cycle(t0 + 171);
                check("lat dv", 32'(data_valid), 32'h1);
                check("A5 data", 32'(data_out), 32'hA5);
            end
        join
        pulse_ack();
        @(negedge clk);
        check("ack clears dv", 32'(data_valid), 32'h0);
        cycles(5);

        // 0x3C with wrong parity bit
        t0 = cyc;
        fork
            send_frame(8'h3C, 1, 0, 0);
            begin
                at_cycle(t0 + 171);
                check("3C parity_err", 32'(parity_err), 32'h1);
                check("3C dv", 32'(data_valid), 32'h0);
                check("3C data kept", 32'(data_out), 32'hA5);
                at_cycle(t0 + 172);
                check("3C pulse end", 32'(parity_err), 32'h0);
            end
        join
        cycles(5);

        // 0x55 with stop bit 0, line held low 40 more cycles
        t0 = cyc;
        fork
            send_frame(8'h55, 0, 1, 40);
            begin
                at_cycle(t0 + 171);
                check("55 frame_err", 32'(frame_err), 32'h1);
                check("55 parity_err", 32'(parity_err), 32'h0);
            end
        join
        cycles(40);
        t0 = cyc;
        fork
            send_frame(8'h0F, 0, 0, 0);
            begin
                at_cycle(t0 + 171);
                check("0F data", 32'(data_out), 32'h0F);
            end
        join
        pulse_ack();
        cycles(5);

        // 6-cycle start glitch, then 0x81
        rx_line = 1'b0;
        cycles(6);
        rx_line = 1'b1;
        cycles(30);
        check("glitch dv", 32'(data_valid), 32'h0);
        t0 = cyc;
        fork
            send_frame(8'h81, 0, 0, 0);
            begin
                at_cycle(t0 + 171);
                check("81 data", 32'(data_out), 32'h81);
            end
        join
        pulse_ack();
        cycles(5);

        // back-to-back, no ack -> overrun
        t0 = cyc;
        fork
            begin
                send_frame(8'h11, 0, 0, 0);
                send_frame(8'h22, 0, 0, 0);
            end
            begin
                at_cycle(t0 + FRAME + 171);
                check("ovr data", 32'(data_out), 32'h22);
                check("ovr flag", 32'(overrun), 32'h1);
            end
        join
        pulse_ack();
        @(negedge clk);
        check("ovr ack dv", 32'(data_valid), 32'h0);
        check("ovr ack flag", 32'(overrun), 32'h0);
        cycles(5);

        // back-to-back with ack at the second commit
        t0 = cyc;
        fork
            begin
                send_frame(8'h11, 0, 0, 0);
                send_frame(8'h22, 0, 0, 0);
            end
            begin
                at_cycle(t0 + FRAME + 170);
                data_ack = 1'b1;
                @(posedge clk);
                #1 data_ack = 1'b0;
                at_cycle(t0 + FRAME + 171);
                check("ackc dv", 32'(data_valid), 32'h1);
                check("ackc data", 32'(data_out), 32'h22);
                check("ackc ovr", 32'(overrun), 32'h0);
            end
        join
        pulse_ack();
        cycles(5);

        // reset during data bit 3 with the line low
        rx_line = 1'b0;
        cycles(CPB + 3 * CPB + CPB / 2);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        check("mid rst dv", 32'(data_valid), 32'h0);
        check("mid rst data", 32'(data_out), 32'h0);
        cycles(60);
        rx_line = 1'b1;
        cycles(32);
        t0 = cyc;
        fork
            send_frame(8'hC3, 0, 0, 0);
            begin
                at_cycle(t0 + 171);
                check("C3 data", 32'(data_out), 32'hC3);
                check("C3 dv", 32'(data_valid), 32'h1);
            end
        join
        cycles(3);

        // randomized frames with random acks
        rand_ack = 1;
        for (int k = 0; k < 25; k++) begin
            logic [7:0] d;
            bit bp, bs;
            int gap;
            d   = 8'($urandom_range(0, 255));
            bp  = ($urandom_range(0, 7) == 0);
            bs  = ($urandom_range(0, 7) == 0);
            gap = bs ? 40 : $urandom_range(0, 24);
            send_frame(d, bp, bs, 0);
            if (gap > 0) cycles(gap);
        end
        @(negedge clk);
        rand_ack = 0;
        data_ack = 1'b0;
        cycles(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
